hazard_unit: RTL
================

// Module: hazard_unit
// PURPOSE
//  Parametrised hazard/forwarding controller for the fewcore pipeline; sits beside decode.
//  Keeps a shadow pipeline of in-flight destination registers, FWD_DEPTH stages deep.
//  Drives per-operand forward selects, load-use stalls and branch-taken flushes.
//  Keeps saturating stall/flush counters for performance runs.
// PARAMETERS
//  REG_ADDR_W   5  register index width (x0 hardwired zero)
//  FWD_DEPTH    2  number of post-decode stages that can forward (>=1)
//  LOAD_LAT     2  first shadow stage (1-based) at which load data is forwardable (1..FWD_DEPTH)
//  FLUSH_CYCLES 1  cycles decode is squashed after a taken branch (>=1)
//  CNT_W        16 perf counter width
// PORTS
//  clk           in   1            clock, rising edge
//  reset         in   1            asynchronous, active-low reset
//  id_valid      in   1            decode holds a real instruction
//  id_rs1        in   REG_ADDR_W   decode source 1 index
//  id_rs2        in   REG_ADDR_W   decode source 2 index
//  id_rs1_used   in   1            instruction reads rs1
//  id_rs2_used   in   1            instruction reads rs2
//  id_rd         in   REG_ADDR_W   decode destination index
//  id_wen        in   1            instruction writes rd
//  id_is_load    in   1            instruction is a load
//  ex_branch_taken in 1            execute resolved a taken branch this cycle
//  stall         out  1            hold fetch/decode, bubble into execute (combinational)
//  flush         out  1            squash decode instruction (registered counter != 0, or ex_branch_taken)
//  fwd_rs1_sel   out  $clog2(FWD_DEPTH+1)  0=register file, k=shadow stage k
//  fwd_rs2_sel   out  $clog2(FWD_DEPTH+1)  as fwd_rs1_sel
//  stall_cnt     out  CNT_W        saturating count of stall cycles
//  flush_cnt     out  CNT_W        saturating count of flush cycles
// BEHAVIOUR
//  - Reset: all shadow entries invalid, flush counter 0, stall=flush=0, sel=0, counters 0.
//  - Shadow entry k (1..FWD_DEPTH) holds {valid,wen,is_load,rd}. Each clk: e[k+1]<=e[k];
//    e[1]<=decode instr if id_valid & ~stall & ~flush, else bubble (valid=0).
//  - Entries leaving e[FWD_DEPTH] have written the regfile (write-first); no tracking needed.
//  - Match per operand: used & rs!=0 & e[k].valid & e[k].wen & e[k].rd==rs.
//    Youngest (smallest k) match wins; sel=k; no match -> sel=0. Same rule for both operands.
//  - Load-use: youngest match is a load and k<LOAD_LAT -> stall=1, sel forced 0.
//    Either operand may trigger. Stall repeats each cycle until the load reaches LOAD_LAT.
//  - stall only when id_valid=1; flush has priority: flush=1 forces stall=0.
//  - Flush: ex_branch_taken loads counter with FLUSH_CYCLES-1; flush=ex_branch_taken | (cnt!=0).
//    Counter decrements to 0. A new ex_branch_taken while counting reloads it (no accumulation).
//  - Flush squashes decode only; shadow entries are not invalidated (older than branch, must commit).
//  - Counters +1 per cycle with stall (resp. flush) high; hold at 2^CNT_W-1.
//  - Reset asserted mid-operation clears everything immediately.
//    First clk after deassert behaves as an empty pipeline.
//  - Outputs stall/flush/sel are combinational from inputs + registered state; zero latency.
// STRUCTURE
//  - fewcore_pkg: REG_ADDR_W, FWD_SEL_RF=0, typedef inflight_t {valid,wen,is_load,rd}.
//  - Sub-module hazard_shadow: FWD_DEPTH-deep inflight_t shift register with bubble insert.
//    Exposes all entries flat.
//  - Top: match/priority logic, flush counter, perf counters.
// TESTING (defaults unless noted)
//  1 add x5 then add x6,x5,x5 next cycle -> fwd_rs1_sel=fwd_rs2_sel=1, stall=0.
//  2 lw x7 then use x7 next cycle -> stall=1 one cycle.
//    Next cycle fwd sel=2, stall=0; stall_cnt=1.
//  3 write x0 then read x0 -> sel=0, stall=0; add x5 at stage1 and stage2 -> sel=1 (youngest).
//  4 ex_branch_taken pulse with FLUSH_CYCLES=3 -> flush high 3 cycles.
//    Second pulse at cycle 2 extends to cycle 4; flush_cnt=5.
//  5 load-use stall coincident with ex_branch_taken -> flush=1, stall=0, e[1] bubble.
//  6 reset deasserted-asserted during stall -> all outputs 0 asynchronously, counters 0.

Source files
------------

// File: rtl/fewcore_pkg.sv
// fewcore_pkg: shared types and constants for the fewcore hazard/forwarding logic.
//   REG_ADDR_W  - architectural register index width (x0 reads as zero)
//   FWD_SEL_RF  - forward-select value meaning "take operand from the register file"
//   inflight_t  - one shadow-pipeline entry describing an in-flight destination write
package fewcore_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FWD_SEL_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] rd;
    } inflight_t;

endpackage

// File: rtl/hazard_shadow.sv
// hazard_shadow: FWD_DEPTH-deep shift register of in-flight instruction descriptors.
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset; clears every entry to invalid
//   in_entry  in   descriptor entering stage 1 (caller zeroes .valid to insert a bubble)
//   entries   out  all stages, flat; index 0 is stage 1 (youngest)
module hazard_shadow
    import fewcore_pkg::*;
#(
    parameter int unsigned FWD_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  inflight_t                   in_entry,
    output inflight_t [FWD_DEPTH-1:0]   entries
);

    inflight_t [FWD_DEPTH-1:0] ent_q;
    inflight_t [FWD_DEPTH-1:0] ent_d;

    always_comb begin
        ent_d    = ent_q;
        ent_d[0] = in_entry;
        for (int unsigned i = 1; i < FWD_DEPTH; i++) begin
            ent_d[i] = ent_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign entries = ent_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: hazard/forwarding controller sitting beside decode.
//   clk, reset        rising-edge clock; asynchronous active-low reset
//   id_*              decode-stage instruction: valid, sources (+used), destination, wen, is_load
//   ex_branch_taken   execute resolved a taken branch this cycle
//   stall             hold fetch/decode, bubble into execute (load-use, combinational)
//   flush             squash the decode instruction (branch now or flush window still open)
//   fwd_rs1/2_sel     0 = register file, k = forward from shadow stage k
//   stall_cnt/flush_cnt  saturating performance counters
module hazard_unit
    import fewcore_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = fewcore_pkg::REG_ADDR_W,
    parameter int unsigned FWD_DEPTH    = 2,
    parameter int unsigned LOAD_LAT     = 2,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               id_valid,
    input  logic [REG_ADDR_W-1:0]              id_rs1,
    input  logic [REG_ADDR_W-1:0]              id_rs2,
    input  logic                               id_rs1_used,
    input  logic                               id_rs2_used,
    input  logic [REG_ADDR_W-1:0]              id_rd,
    input  logic                               id_wen,
    input  logic                               id_is_load,
    input  logic                               ex_branch_taken,
    output logic                               stall,
    output logic                               flush,
    output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_rs1_sel,
    output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_rs2_sel,
    output logic [CNT_W-1:0]                   stall_cnt,
    output logic [CNT_W-1:0]                   flush_cnt
);

    localparam int unsigned SEL_W = $clog2(FWD_DEPTH + 1);
    localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    inflight_t [FWD_DEPTH-1:0] ents;
    inflight_t                 shadow_in;

    logic             rs1_hit, rs2_hit;
    logic             rs1_load, rs2_load;
    logic [SEL_W-1:0] rs1_k, rs2_k;
    logic             load_use;

    logic [FC_W-1:0]  flush_left_q, flush_left_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    hazard_shadow #(
        .FWD_DEPTH (FWD_DEPTH)
    ) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .in_entry (shadow_in),
        .entries  (ents)
    );

    // Scan oldest to youngest so the youngest matching stage is the one left standing.
    always_comb begin
        rs1_hit  = 1'b0;
        rs1_load = 1'b0;
        rs1_k    = '0;
        rs2_hit  = 1'b0;
        rs2_load = 1'b0;
        rs2_k    = '0;
        for (int unsigned n = 0; n < FWD_DEPTH; n++) begin
            if (id_rs1_used && (id_rs1 != '0) && ents[FWD_DEPTH-1-n].valid &&
                ents[FWD_DEPTH-1-n].wen && (ents[FWD_DEPTH-1-n].rd == id_rs1)) begin
                rs1_hit  = 1'b1;
                rs1_load = ents[FWD_DEPTH-1-n].is_load;
                rs1_k    = SEL_W'(FWD_DEPTH - n);
            end
            if (id_rs2_used && (id_rs2 != '0) && ents[FWD_DEPTH-1-n].valid &&
                ents[FWD_DEPTH-1-n].wen && (ents[FWD_DEPTH-1-n].rd == id_rs2)) begin
                rs2_hit  = 1'b1;
                rs2_load = ents[FWD_DEPTH-1-n].is_load;
                rs2_k    = SEL_W'(FWD_DEPTH - n);
            end
        end
    end

    always_comb begin
        load_use = (rs1_hit && rs1_load && (rs1_k < SEL_W'(LOAD_LAT))) ||
                   (rs2_hit && rs2_load && (rs2_k < SEL_W'(LOAD_LAT)));
        flush    = ex_branch_taken || (flush_left_q != '0);
        // A squashed instruction never needs to wait for its operands.
        stall    = id_valid && !flush && load_use;

        fwd_rs1_sel = stall ? SEL_W'(FWD_SEL_RF) : rs1_k;
        fwd_rs2_sel = stall ? SEL_W'(FWD_SEL_RF) : rs2_k;

        shadow_in         = '0;
        shadow_in.valid   = id_valid && !stall && !flush;
        shadow_in.wen     = id_wen;
        shadow_in.is_load = id_is_load;
        shadow_in.rd      = id_rd;
    end

    always_comb begin
        if (ex_branch_taken) begin
            flush_left_d = FC_W'(FLUSH_CYCLES - 1);
        end else if (flush_left_q != '0) begin
            flush_left_d = flush_left_q - FC_W'(1);
        end else begin
            flush_left_d = flush_left_q;
        end

        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_left_q <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            flush_left_q <= flush_left_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
